// File: rtl/avmm_mover_pkg.sv
// Shared definitions for the Avalon-MM block mover: FSM states, op codes, bus constants.
package avmm_mover_pkg;

  localparam int unsigned AVM_DATA_W = 32;
  localparam logic [3:0]  AVM_BE_ALL = 4'hF;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/avmm_mover_lat_ctr.sv
// Read-latency down-counter: raises o_valid in the cycle the slave's readdata is valid.
module avmm_mover_lat_ctr #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_valid
);

  localparam logic [1:0] LOAD_VAL = 2'(RD_LATENCY - 1);

  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_valid = i_en && (r_cnt == '0);

endmodule

// File: rtl/avmm_block_mover.sv
// Avalon-MM initiator performing block copy / block fill on the data memory slave.
// Optional running write checksum: define AVMM_BLOCK_MOVER_CHECKSUM_EN.
module avmm_block_mover
  import avmm_mover_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned LEN_W      = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_W-1:0]     cmd_src,
  input  logic [ADDR_W-1:0]     cmd_dst,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [AVM_DATA_W-1:0] cmd_fill,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [3:0]            avm_byteenable,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_waitrequest,
  output logic                  avm_clken
`ifdef AVMM_BLOCK_MOVER_CHECKSUM_EN
  ,
  output logic [AVM_DATA_W-1:0] checksum
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_e                r_state;
  logic                  r_op;
  logic [ADDR_W-1:0]     r_src;
  logic [ADDR_W-1:0]     r_dst;
  logic [LEN_W-1:0]      r_rem;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cs;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_W-1:0]     r_addr;
  logic [AVM_DATA_W-1:0] r_wdata;

  logic [LEN_W-1:0] w_len;
  logic             w_accept;
  logic             w_rd_fire;
  logic             w_wr_fire;
  logic             w_rd_wait;
  logic             w_rd_valid;

  always_comb begin
    w_len = cmd_len;
    if (cmd_len > MAX_LEN) w_len = MAX_LEN;
  end

  assign w_accept  = r_cmd_ready && cmd_valid;
  assign w_rd_fire = (r_state == ST_RD_ISSUE) && !avm_waitrequest;
  assign w_wr_fire = (r_state == ST_WR_ISSUE) && !avm_waitrequest;
  assign w_rd_wait = (r_state == ST_RD_WAIT);

  avmm_mover_lat_ctr #(
    .RD_LATENCY(RD_LATENCY)
  ) u_lat_ctr (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_rd_fire),
    .i_en   (w_rd_wait),
    .o_valid(w_rd_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_COPY;
      r_src       <= '0;
      r_dst       <= '0;
      r_rem       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cs        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_op        <= cmd_op;
            r_src       <= cmd_src;
            r_dst       <= cmd_dst;
            r_rem       <= w_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_len == '0) begin
              r_state <= ST_FINISH;
            end else if (cmd_op == OP_FILL) begin
              r_state <= ST_WR_ISSUE;
              r_cs    <= 1'b1;
              r_wr    <= 1'b1;
              r_addr  <= cmd_dst;
              r_wdata <= cmd_fill;
            end else begin
              r_state <= ST_RD_ISSUE;
              r_cs    <= 1'b1;
              r_rd    <= 1'b1;
              r_addr  <= cmd_src;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (!avm_waitrequest) begin
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (w_rd_valid) begin
            r_wdata <= avm_readdata;
            r_cs    <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= r_dst;
            r_state <= ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (!avm_waitrequest) begin
            r_rem <= r_rem - LEN_W'(1);
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_cs    <= 1'b0;
              r_wr    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else if (r_op == OP_FILL) begin
              r_addr <= r_dst + ADDR_W'(1);
            end else begin
              r_wr    <= 1'b0;
              r_rd    <= 1'b1;
              r_addr  <= r_src + ADDR_W'(1);
              r_state <= ST_RD_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          // Zero-length commands reach FINISH with done low; they pulse done one
          // cycle later (back in IDLE) so busy and done never overlap for them.
          r_done      <= ~r_done;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_read       = r_rd;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = AVM_BE_ALL;
  assign avm_clken      = 1'b1;

`ifdef AVMM_BLOCK_MOVER_CHECKSUM_EN
  logic [AVM_DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_wr_fire) begin
      r_sum <= r_sum + r_wdata;
    end
  end

  assign checksum = r_sum;
`endif

endmodule

// File: doc/avmm_block_mover.md
Name: avmm_block_mover

Overview:
- Avalon-MM initiator that drives the single-port on-chip data memory slave (32-bit, byte-enabled) to perform block copy and block fill operations.
- Sits between a processor-side command interface and the memory's s1/s2 slave port.
- Frees the pipeline from word-by-word load/store loops during memory initialisation and memcpy/memset.

Parameters:
- ADDR_W, 11, word-address width of the memory slave (2048 words).
- LEN_W, 12, width of the word-count field (max length 2^ADDR_W).
- RD_LATENCY, 1, fixed slave read latency in clocks, counted from the accepted read cycle to valid readdata; legal range 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_op  in  1  0=copy, 1=fill.
- cmd_src  in  ADDR_W  source word address (copy only).
- cmd_dst  in  ADDR_W  destination word address.
- cmd_len  in  LEN_W  number of words.
- cmd_fill  in  32  fill pattern (fill only).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  word address to slave.
- avm_chipselect  out  1  slave select.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_byteenable  out  4  always 4'b1111.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall; tie 0 for the on-chip RAM.
- avm_clken  out  1  slave clock enable; constant 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: cmd_ready=1, busy=0, done=0, avm_chipselect=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=4'hF, avm_clken=1.
- Command accept: a command is accepted on a clock edge where cmd_valid && cmd_ready. cmd_src, cmd_dst, cmd_len, cmd_op and cmd_fill are registered internally; later changes on those inputs are ignored.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, FINISH.
  - IDLE -> FINISH when the accepted cmd_len == 0.
  - IDLE -> RD_ISSUE when copy.
  - IDLE -> WR_ISSUE when fill.
  - RD_ISSUE: chipselect=1, read=1, address=src_ptr. Holds while waitrequest=1. On an accepted cycle, load the latency counter with RD_LATENCY-1 and go to RD_WAIT.
  - RD_WAIT: strobes low. When the counter reaches 0, capture avm_readdata into the data register on that edge, then go to WR_ISSUE.
  - WR_ISSUE: chipselect=1, write=1, address=dst_ptr, writedata = data register (copy) or cmd_fill (fill). Holds while waitrequest=1. On an accepted cycle: decrement remaining, increment the pointers, then go to FINISH if remaining was 1, else to RD_ISSUE (copy) or stay in WR_ISSUE (fill).
  - FINISH: done=1 for exactly one cycle, then go to IDLE.
- Strobes: read and write are never asserted in the same cycle. chipselect=1 only when one of the strobes is high. Address, data and strobes are registered outputs and are held stable while waitrequest=1.
- Throughput:
  - Copy: one word per (RD_LATENCY+2) cycles with waitrequest=0.
  - Fill: one word per cycle.
- Command latency: busy rises the cycle after acceptance. Length N fill with no stalls: done asserts N+1 cycles after acceptance.
- Address arithmetic: pointers increment modulo 2^ADDR_W; the wrap from 0x7FF to 0x000 is silent.
- Length: cmd_len values above 2^ADDR_W are clamped to 2^ADDR_W.
- Overlap: the copy is strictly forward (ascending addresses). When dst is inside (src, src+len), the result is a forward-propagation smear. This behaviour is defined, and software must not depend on it being memmove.
- cmd_valid while busy: not accepted (cmd_ready=0); the command is held off until IDLE.
- Reset mid-operation: aborts immediately, no done pulse. Any write already accepted by the slave is complete; the memory contents beyond that point are unchanged.

Optional Feature:
- Macro: AVMM_BLOCK_MOVER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum[31:0], a running 32-bit wrapping sum of every word written during the current operation.
  - The sum clears on command acceptance and is valid (stable) from the done pulse until the next acceptance.
  - Reset value 0.
- When not defined: the port and the adder are absent; all other behaviour is identical.

Decomposition:
- Shared package avmm_mover_pkg holds:
  - the FSM state enumeration;
  - the OP_COPY/OP_FILL constants;
  - AVM_DATA_W=32 and AVM_BE_ALL=4'hF.
- One sub-module, avmm_mover_lat_ctr: a small down-counter that generates the read-data-valid strobe from RD_LATENCY. Everything else stays in the top.

Test Plan:
- Fill, dst=0x010, len=4, fill=0xDEADBEEF -> four writes at 0x010..0x013, one per cycle. done asserts 5 cycles after acceptance, and memory readback is 0xDEADBEEF at each address.
- Copy, memory preloaded 0x100..0x102 = 0x11,0x22,0x33; src=0x100, dst=0x200, len=3 -> read/write alternation with a RD_LATENCY gap. 0x200..0x202 = 0x11,0x22,0x33, and done fires once.
- len=0 -> no chipselect at any time; done pulses 2 cycles after acceptance; busy is high for 1 cycle.
- Wrap: fill dst=0x7FE, len=3, fill=0x5 -> writes land at 0x7FE, 0x7FF, 0x000.
- Stall: waitrequest held high for 3 cycles on the second write of a fill -> address and writedata are held stable; no word is skipped or duplicated; done is delayed by exactly 3 cycles.
- Reset mid-copy: reset_n asserted after the 2nd write of a len=8 copy -> outputs return to reset values asynchronously; no done pulse; destination words 3..8 are unchanged. With the macro defined, checksum for copy 0x1 + 0x2 + 0xFFFFFFFF is 0x00000002.
